// File: rtl/cache_pkg.sv
// Shared definitions for the cache miss handler: FSM state encoding,
// RAM direction codes and default data/address widths.
package cache_pkg;

  localparam int D_WIDTH = 8;
  localparam int A_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WB   = 2'd1,
    RD   = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

endpackage

// File: rtl/cache_miss_ctrl_access_timer.sv
// RAM access timer: counts the cycles of one RAM access (0..RAM_LAT-1).
// Restarted by load on every state entry; done flags the last access cycle.
module access_timer #(
  parameter int RAM_LAT = 2
) (
  input  logic clk,
  input  logic clr,
  input  logic load,
  output logic done
);

  localparam int CW = $clog2(RAM_LAT) + 1;
  localparam logic [CW-1:0] LAST = CW'(RAM_LAT - 1);

  logic [CW-1:0] cnt;

  // Cycle counter, restarted on load, parks at the last cycle
  always_ff @(posedge clk or negedge clr) begin
    if (!clr)             cnt <= '0;
    else if (load)        cnt <= '0;
    else if (cnt != LAST) cnt <= cnt + CW'(1);
  end

  assign done = (cnt == LAST);

endmodule

// File: rtl/cache_miss_ctrl.sv
// Cache miss controller: writes back a dirty victim, reads the missed word
// from RAM and returns it to the cache as a one-cycle fill strobe.
// Optional MISS_STATS_EN adds saturating miss/write-back counters.
module cache_miss_ctrl
  import cache_pkg::*;
#(
  parameter int d_width = D_WIDTH,
  parameter int a_width = A_WIDTH,
  parameter int RAM_LAT = 2
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               miss_req,
  input  logic [a_width-1:0] miss_addr,
  input  logic [a_width-1:0] evict_addr,
  input  logic [d_width-1:0] evict_data,
  input  logic               evict_dirty,
  output logic               miss_busy,
  output logic               fill_valid,
  output logic [a_width-1:0] fill_addr,
  output logic [d_width-1:0] fill_data,
  output logic               ram_enab,
  output logic               ram_rw,
  output logic [a_width-1:0] ram_addr,
  output logic [d_width-1:0] ram_data_in,
  input  logic [d_width-1:0] ram_data_out
`ifdef MISS_STATS_EN
  ,
  output logic [15:0]        miss_count,
  output logic [15:0]        wb_count
`endif
);

  state_t state, next;

  logic               accept;
  logic               tdone;
  logic [a_width-1:0] cap_maddr;
  logic [a_width-1:0] cap_eaddr;
  logic [d_width-1:0] cap_edata;
  logic [a_width-1:0] wb_addr;
  logic [d_width-1:0] wb_data;
  logic [a_width-1:0] rd_addr;

  assign accept = (state == IDLE) && miss_req;

  access_timer #(.RAM_LAT(RAM_LAT)) u_timer (
    .clk  (clk),
    .clr  (clr),
    .load (next != state),
    .done (tdone)
  );

  // State register
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) state <= IDLE;
    else      state <= next;
  end

  // Next-state logic and RAM address/data sources; outputs are registered
  // from next state, so the accepting edge must take the live inputs
  always_comb begin
    next    = state;
    wb_addr = cap_eaddr;
    wb_data = cap_edata;
    rd_addr = cap_maddr;
    if (accept) begin
      wb_addr = evict_addr;
      wb_data = evict_data;
      rd_addr = miss_addr;
    end
    case (state)
      IDLE: if (miss_req) next = evict_dirty ? WB : RD;
      WB:   if (tdone)    next = RD;
      RD:   if (tdone)    next = DONE;
      DONE:               next = IDLE;
      default:            next = IDLE;
    endcase
  end

  // Capture the request on the accepting edge
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      cap_maddr <= '0;
      cap_eaddr <= '0;
      cap_edata <= '0;
    end else if (accept) begin
      cap_maddr <= miss_addr;
      cap_eaddr <= evict_addr;
      cap_edata <= evict_data;
    end
  end

  // Registered outputs derived from the state being entered
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      miss_busy   <= 1'b0;
      fill_valid  <= 1'b0;
      fill_addr   <= '0;
      fill_data   <= '0;
      ram_enab    <= 1'b0;
      ram_rw      <= RW_READ;
      ram_addr    <= '0;
      ram_data_in <= '0;
    end else begin
      miss_busy  <= (next != IDLE);
      fill_valid <= (next == DONE);
      ram_enab   <= (next == WB) || (next == RD);
      if (next == WB) begin
        ram_rw      <= RW_WRITE;
        ram_addr    <= wb_addr;
        ram_data_in <= wb_data;
      end else if (next == RD) begin
        ram_rw   <= RW_READ;
        ram_addr <= rd_addr;
      end
      if (state == RD && next == DONE) begin
        fill_data <= ram_data_out;
        fill_addr <= cap_maddr;
      end
    end
  end

`ifdef MISS_STATS_EN
  // Saturating counters of accepted misses and write-backs
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      miss_count <= '0;
      wb_count   <= '0;
    end else begin
      if (accept && miss_count != '1)                wb_count   <= wb_count;
      if (accept && miss_count != '1)                miss_count <= miss_count + 16'd1;
      if (accept && evict_dirty && wb_count != '1)   wb_count   <= wb_count + 16'd1;
    end
  end
`endif

endmodule
